// File: rtl/float_div_pkg.sv
// float_div_pkg: shared state encoding and constants for the single-precision divider.
package float_div_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, DIVIDE, NORM, DONE} state_t;
    localparam int         BIAS    = 127;
    localparam int         QBITS   = 26;
    localparam logic [7:0] EXP_INF = 8'hFF;
endpackage

// File: rtl/div_core.sv
// div_core: restoring mantissa divider producing floor(dividend*2^25/divisor), one bit per cycle.
module div_core
    import float_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [23:0] dividend,
    input  logic [23:0] divisor,
    output logic [25:0] quotient,
    output logic [23:0] remainder,
    output logic        finished
);
    logic [23:0] dvs;
    logic [23:0] dsr;
    logic [4:0]  cnt;
    logic [24:0] part;
    logic [24:0] diff;
    logic        ge;
    // The load edge already retires the first quotient bit, so 25 more steps follow.
    always_comb begin
        part = load ? {1'b0, dividend} : {remainder, 1'b0};
        dsr  = load ? divisor : dvs;
        diff = part - {1'b0, dsr};
        ge   = part >= {1'b0, dsr};
    end
    // High during the cycle whose edge retires the last quotient bit.
    assign finished = cnt == 5'd1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvs       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (load || cnt != 5'd0) begin
            dvs       <= dsr;
            cnt       <= load ? 5'(QBITS - 1) : cnt - 5'd1;
            quotient  <= load ? {25'd0, ge} : {quotient[24:0], ge};
            remainder <= ge ? diff[23:0] : part[23:0];
        end
    end
endmodule

// File: rtl/float_divider.sv
// float_divider: iterative IEEE-754 single-precision divider with special-case
// classification, round-half-up and overflow/underflow flushing.
module float_divider
    import float_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        exception,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);
    state_t             state, state_next;
    logic [31:0]        op_a, op_b;
    logic               sign, a_zero, b_zero, any_inf, special, load, finished;
    logic [25:0]        quotient;
    logic [23:0]        rem_unused;
    logic [31:0]        special_result;
    logic signed [9:0]  exp_raw, exp_adj, exp_rnd;
    logic [22:0]        mant;
    logic               guard, ovf, unf;
    logic [23:0]        rounded;

    div_core u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .dividend ({1'b1, op_a[22:0]}),
        .divisor  ({1'b1, op_b[22:0]}),
        .quotient (quotient),
        .remainder(rem_unused),
        .finished (finished)
    );

    // Zero exponent means zero: denormal mantissas are flushed.
    always_comb begin
        sign           = op_a[31] ^ op_b[31];
        a_zero         = op_a[30:23] == 8'd0;
        b_zero         = op_b[30:23] == 8'd0;
        any_inf        = op_a[30:23] == EXP_INF || op_b[30:23] == EXP_INF;
        special        = any_inf | a_zero | b_zero;
        special_result = (b_zero && !a_zero && !any_inf) ? {sign, EXP_INF, 23'd0} : {sign, 31'd0};
        load           = state == SETUP && !special;
        exp_raw        = {2'b00, op_a[30:23]} - {2'b00, op_b[30:23]} + 10'(BIAS);
        mant           = quotient[25] ? quotient[24:2] : quotient[23:1];
        guard          = quotient[25] ? quotient[1] : quotient[0];
        exp_adj        = quotient[25] ? exp_raw : exp_raw - 10'sd1;
        rounded        = {1'b0, mant} + {23'd0, guard};
        exp_rnd        = exp_adj + {9'd0, rounded[23]};
        ovf            = exp_rnd >= 10'sd255;
        unf            = exp_rnd <= 10'sd0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? SETUP : IDLE;
            SETUP:   state_next = special ? DONE : DIVIDE;
            DIVIDE:  state_next = finished ? NORM : DIVIDE;
            NORM:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            exception   <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            done  <= state == DONE;
            if (state == IDLE && start) begin
                op_a        <= a;
                op_b        <= b;
                busy        <= 1'b1;
                exception   <= 1'b0;
                overflow    <= 1'b0;
                underflow   <= 1'b0;
                div_by_zero <= 1'b0;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end
            if (state == SETUP && special) begin
                result      <= special_result;
                exception   <= any_inf | (a_zero & b_zero);
                div_by_zero <= b_zero & ~a_zero & ~any_inf;
            end
            if (state == NORM) begin
                result    <= ovf ? {sign, EXP_INF, 23'd0} : unf ? {sign, 31'd0} : {sign, exp_rnd[7:0], rounded[22:0]};
                overflow  <= ovf;
                underflow <= unf;
            end
        end
    end
endmodule

// File: tb/tb_float_divider.sv
// tb_float_divider: scoreboard bench for float_divider covering normal, special,
// busy-ignore and mid-operation reset behaviour.
module tb_float_divider;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b;
    logic        start;
    logic        busy, done;
    logic [31:0] result;
    logic        exception, overflow, underflow, div_by_zero;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        int          cap;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    float_divider dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .exception  (exception),
        .overflow   (overflow),
        .underflow  (underflow),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Flags are packed {exception, overflow, underflow, div_by_zero}.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("flags", {exception, overflow, underflow, div_by_zero}, e.fl);
                check("latency", cyc - e.cap, e.lat);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] res,
                          input logic [3:0] fl, input int lat, input int poke);
        int n;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back('{res, fl, lat, cyc});
        check("busy_after_capture", busy, 1);
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            a     = 32'h3F800000;
            b     = 32'h40400000;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    vec_t vecs[12];

    initial begin
        vecs = '{
            '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28},
            '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28},
            '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 2},
            '{32'h00000000, 32'h00000000, 32'h00000000, 4'b1000, 2},
            '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0100, 28},
            '{32'h00800000, 32'h4B000000, 32'h00000000, 4'b0010, 28},
            '{32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 2},
            '{32'h7FC00000, 32'h3F800000, 32'h00000000, 4'b1000, 2},
            '{32'hC1000000, 32'h40000000, 32'hC0800000, 4'b0000, 28},
            '{32'h3F800000, 32'h3F7FFFFF, 32'h3F800001, 4'b0000, 28},
            '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 2},
            '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0001, 2}
        };
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {exception, overflow, underflow, div_by_zero}, 0);
        @(negedge clk);
        reset = 1'b1;
        foreach (vecs[i]) run_op(vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].fl, vecs[i].lat, 0);
        // New operands offered in DIVIDE cycle 10 must be ignored.
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 11);
        a     = 32'h40C00000;
        b     = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_result", result, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_flags", {exception, overflow, underflow, div_by_zero}, 0);
        @(negedge clk);
        reset = 1'b1;
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, 0);
        repeat (40) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/float_divider.md
FLOAT_DIVIDER -- requirements
Module: float_divider

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port a  input  32  IEEE-754 single dividend.
REQ-004 SHALL have port b  input  32  IEEE-754 single divisor.
REQ-005 SHALL have port start  input  1  request; a/b captured on the edge where start=1 and busy=0.
REQ-006 SHALL have port busy  output  1  high from the cycle after capture until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse; result and flags valid.
REQ-008 SHALL have port result  output  32  quotient, held until the next capture.
REQ-009 SHALL have ports exception, overflow, underflow, div_by_zero  output  1 each  status, held with result.

Function
REQ-010 SHALL implement states IDLE, SETUP, DIVIDE, NORM, DONE; DONE returns to IDLE after one cycle.
REQ-011 SHALL ignore start while busy=1 or in DONE; captured operands are not disturbed.
REQ-012 SHALL set sign = a[31] ^ b[31] for every result, including special cases.
REQ-013 SHALL flush inputs with exponent 0 to zero (denormals not supported).
REQ-014 SETUP SHALL classify: any exponent 255 -> exception=1, result 0; a zero and b zero -> exception=1, result 0; b zero only -> div_by_zero=1, result {sign,8'hFF,23'd0}; a zero only -> result {sign,31'd0}; each goes directly to DONE.
REQ-015 Special-case latency SHALL be exactly 2 edges from the capture edge to the edge raising done.
REQ-016 SHALL compute exponent as a 10-bit signed value ea - eb + 127.
REQ-017 DIVIDE SHALL be restoring division, one quotient bit per cycle, 26 cycles, giving q = floor(Ma*2^25/Mb), Ma/Mb with hidden bit, plus remainder.
REQ-018 NORM: if q[25]=1 -> mantissa q[24:2], guard q[1], sticky q[0]|(rem!=0); else mantissa q[23:1], guard q[0], exponent-1.
REQ-019 Rounding SHALL be round-half-up: mantissa+guard; carry out of 23 bits -> mantissa 0, exponent+1.
REQ-020 Exponent >= 255 after rounding -> overflow=1, result {sign,8'hFF,23'd0}.
REQ-021 Exponent <= 0 after rounding -> underflow=1, result {sign,31'd0}.
REQ-022 Normal-path latency SHALL be exactly 28 edges from the capture edge to the edge raising done (1 SETUP + 26 DIVIDE + 1 NORM).
REQ-023 Flags SHALL be cleared on every capture; at most one of exception/div_by_zero/overflow/underflow is set per result.
REQ-024 A new start in the IDLE cycle following done SHALL be accepted normally.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, busy=0, done=0, result=0 and all flags 0, without waiting for clk.
REQ-026 Reset mid-operation SHALL abandon the division; no done pulse is produced for that operation.
REQ-027 The first start after reset deassertion SHALL be accepted on the first rising edge.

Structure
REQ-028 Package float_div_pkg SHALL hold the state enum and the constants BIAS=127, QBITS=26, EXP_INF=8'hFF.
REQ-029 The iterative mantissa divider SHALL be sub-module div_core (load, 24-bit operands, 26-bit quotient, remainder, finished); classification, normalisation and rounding stay in float_divider.
REQ-030 result and flags SHALL be registered outputs.

Verification
REQ-031 a=40C00000 (6.0), b=40000000 (2.0) -> result 40400000, no flags, done 28 edges after capture.
REQ-032 a=3F800000, b=40400000 (1/3) -> result 3EAAAAAB (guard rounds up).
REQ-033 a=3F800000, b=00000000 -> result 7F800000, div_by_zero=1, done 2 edges after capture; a=b=0 -> result 0, exception=1.
REQ-034 a=7F7FFFFF, b=3F000000 -> overflow=1, result 7F800000; a=00800000, b=4B000000 -> underflow=1, result 00000000.
REQ-035 start pulsed with new operands at DIVIDE cycle 10 -> ignored, original quotient returned; reset=0 at DIVIDE cycle 5 -> outputs 0 at once, no done, next start gives correct result.
